// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Data-memory arbiter for core, RAS spill/fill engine and loader,
//           with starvation-forced grants for the two secondary ports.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_din,
    input  logic [3:0]  core_be,
    output logic        core_hold,
    input  logic        ras_req,
    input  logic        ras_we,
    input  logic [31:0] ras_addr,
    input  logic [31:0] ras_din,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_din,
    output logic        ras_gnt,
    output logic        ldr_gnt,
    output logic        core_rvalid,
    output logic        ras_rvalid,
    output logic        ldr_rvalid,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam logic [7:0] C_LIMIT   = 8'(STARVE_LIMIT);
    localparam logic       C_SEL_RAS = 1'b0;
    localparam logic       C_SEL_LDR = 1'b1;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_force_sel;
    logic       r_last_forced;
    logic [7:0] r_ras_cnt;
    logic [7:0] r_ldr_cnt;
    logic       r_core_rvalid;
    logic       r_ras_rvalid;
    logic       r_ldr_rvalid;

    logic       w_core_gnt;
    logic       w_ras_gnt;
    logic       w_ldr_gnt;
    logic [7:0] w_ras_cnt_nxt;
    logic [7:0] w_ldr_cnt_nxt;
    logic       w_ras_starved;
    logic       w_ldr_starved;
    logic       w_force_pick;

    // Grant selection; a forced cycle never falls back to another port.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ras_gnt  = 1'b0;
        w_ldr_gnt  = 1'b0;
        if (!rst) begin
            if (r_state == ST_FORCE) begin
                if (r_force_sel == C_SEL_LDR) begin
                    w_ldr_gnt = ldr_req;
                end else begin
                    w_ras_gnt = ras_req;
                end
            end else if (core_req) begin
                w_core_gnt = 1'b1;
            end else if (ras_req) begin
                w_ras_gnt = 1'b1;
            end else if (ldr_req) begin
                w_ldr_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_ras_cnt_nxt = 8'd0;
        w_ldr_cnt_nxt = 8'd0;
        if (ras_req && !w_ras_gnt) begin
            w_ras_cnt_nxt = (r_ras_cnt >= C_LIMIT) ? C_LIMIT : r_ras_cnt + 8'd1;
        end
        if (ldr_req && !w_ldr_gnt) begin
            w_ldr_cnt_nxt = (r_ldr_cnt >= C_LIMIT) ? C_LIMIT : r_ldr_cnt + 8'd1;
        end
    end

    // Looking at the next counter value lets the forced grant land on the
    // cycle right after the limit-th wait.
    assign w_ras_starved = (w_ras_cnt_nxt == C_LIMIT);
    assign w_ldr_starved = (w_ldr_cnt_nxt == C_LIMIT);

    always_comb begin
        w_force_pick = C_SEL_RAS;
        if (w_ras_starved && w_ldr_starved) begin
            w_force_pick = ~r_last_forced;
        end else if (w_ldr_starved) begin
            w_force_pick = C_SEL_LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_NORMAL;
            r_force_sel   <= C_SEL_RAS;
            r_last_forced <= C_SEL_LDR;
            r_ras_cnt     <= 8'd0;
            r_ldr_cnt     <= 8'd0;
        end else begin
            r_ras_cnt <= w_ras_cnt_nxt;
            r_ldr_cnt <= w_ldr_cnt_nxt;
            case (r_state)
                ST_NORMAL: begin
                    if (w_ras_starved || w_ldr_starved) begin
                        r_state       <= ST_FORCE;
                        r_force_sel   <= w_force_pick;
                        r_last_forced <= w_force_pick;
                    end
                end
                ST_FORCE: begin
                    r_state <= ST_NORMAL;
                end
                default: begin
                    r_state <= ST_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rvalid <= 1'b0;
            r_ras_rvalid  <= 1'b0;
            r_ldr_rvalid  <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_gnt & ~core_we;
            r_ras_rvalid  <= w_ras_gnt & ~ras_we;
            r_ldr_rvalid  <= w_ldr_gnt & ~ldr_we;
        end
    end

    always_comb begin
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        mem_we   = 4'd0;
        if (w_core_gnt) begin
            mem_addr = core_addr;
            mem_din  = core_din;
            mem_we   = core_be & {4{core_we}};
        end else if (w_ras_gnt) begin
            mem_addr = ras_addr;
            mem_din  = ras_din;
            mem_we   = {4{ras_we}};
        end else if (w_ldr_gnt) begin
            mem_addr = ldr_addr;
            mem_din  = ldr_din;
            mem_we   = {4{ldr_we}};
        end
    end

    assign mem_en      = w_core_gnt | w_ras_gnt | w_ldr_gnt;
    assign ras_gnt     = w_ras_gnt;
    assign ldr_gnt     = w_ldr_gnt;
    assign core_hold   = core_req & ~w_core_gnt & ~rst;
    // A pulse launched just before reset must not escape during reset.
    assign core_rvalid = r_core_rvalid & ~rst;
    assign ras_rvalid  = r_ras_rvalid & ~rst;
    assign ldr_rvalid  = r_ldr_rvalid & ~rst;
    assign rdata       = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench for dmem_arbiter with a read scoreboard.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_hold;
    logic [31:0] core_addr, core_din;
    logic [3:0]  core_be;
    logic        ras_req, ras_we, ldr_req, ldr_we;
    logic [31:0] ras_addr, ras_din, ldr_addr, ldr_din;
    logic        ras_gnt, ldr_gnt, core_rvalid, ras_rvalid, ldr_rvalid;
    logic [31:0] rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_din(core_din), .core_be(core_be), .core_hold(core_hold),
        .ras_req(ras_req), .ras_we(ras_we), .ras_addr(ras_addr), .ras_din(ras_din),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_din(ldr_din),
        .ras_gnt(ras_gnt), .ldr_gnt(ldr_gnt),
        .core_rvalid(core_rvalid), .ras_rvalid(ras_rvalid), .ldr_rvalid(ldr_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory model with one-cycle read latency
    logic [31:0] ram    [0:255];
    logic [31:0] shadow [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [3:0]  cbe;
        logic [31:0] caddr;
        logic [31:0] cdin;
        logic        rreq;
        logic        rwe;
        logic [31:0] raddr;
        logic [31:0] rdin;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] ldin;
        int          egnt;   // 0 none, 1 core, 2 RAS, 3 loader
        logic [3:0]  ewe;
        logic        ehold;
    } vec_t;

    typedef struct {
        logic [2:0]  rv;     // {core, ras, ldr}
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t  sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(
        input logic creq, input logic cwe, input logic [3:0] cbe,
        input logic [31:0] caddr, input logic [31:0] cdin,
        input logic rreq, input logic rwe, input logic [31:0] raddr, input logic [31:0] rdin,
        input logic lreq, input logic lwe, input logic [31:0] laddr, input logic [31:0] ldin,
        input int egnt, input logic [3:0] ewe, input logic ehold);
        vec_t v;
        v.rst = 1'b0;
        v.creq = creq; v.cwe = cwe; v.cbe = cbe; v.caddr = caddr; v.cdin = cdin;
        v.rreq = rreq; v.rwe = rwe; v.raddr = raddr; v.rdin = rdin;
        v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.ldin = ldin;
        v.egnt = egnt; v.ewe = ewe; v.ehold = ehold;
        return v;
    endfunction

    // Apply one cycle of stimulus, check this cycle's outputs and retire due reads.
    task automatic step(input vec_t v, input string nm);
        logic [2:0]  erv;
        logic [31:0] erd;
        logic [31:0] ea, ed;
        int          idx;
        rst = v.rst;
        core_req = v.creq; core_we = v.cwe; core_be = v.cbe; core_addr = v.caddr; core_din = v.cdin;
        ras_req = v.rreq; ras_we = v.rwe; ras_addr = v.raddr; ras_din = v.rdin;
        ldr_req = v.lreq; ldr_we = v.lwe; ldr_addr = v.laddr; ldr_din = v.ldin;
        @(negedge clk);
        chk({nm, ".grant"}, {29'd0, mem_en, ras_gnt, ldr_gnt},
            {29'd0, v.egnt != 0, v.egnt == 2, v.egnt == 3});
        chk({nm, ".mem_we"}, {28'd0, mem_we}, {28'd0, v.ewe});
        chk({nm, ".hold"}, {31'd0, core_hold}, {31'd0, v.ehold});
        if (v.egnt != 0) begin
            ea = (v.egnt == 1) ? v.caddr : (v.egnt == 2) ? v.raddr : v.laddr;
            ed = (v.egnt == 1) ? v.cdin  : (v.egnt == 2) ? v.rdin  : v.ldin;
            chk({nm, ".addr"}, mem_addr, ea);
            chk({nm, ".din"}, mem_din, ed);
        end
        if (v.rst) sbq.delete();
        erv = 3'b000;
        erd = 32'd0;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            erv = erv | sbq[0].rv;
            erd = sbq[0].data;
            void'(sbq.pop_front());
        end
        chk({nm, ".rvalid"}, {29'd0, core_rvalid, ras_rvalid, ldr_rvalid}, {29'd0, erv});
        if (erv != 3'b000) chk({nm, ".rdata"}, rdata, erd);
        if (v.egnt != 0 && !v.rst) begin
            idx = int'(ea[9:2]);
            if (v.egnt == 1 && v.cwe) begin
                for (int b = 0; b < 4; b++)
                    if (v.cbe[b]) shadow[idx][8*b +: 8] = v.cdin[8*b +: 8];
            end else if ((v.egnt == 2 && v.rwe) || (v.egnt == 3 && v.lwe)) begin
                shadow[idx] = ed;
            end else if (!(v.egnt == 1 && v.cwe)) begin
                sbq.push_back('{rv: (v.egnt == 1) ? 3'b100 : (v.egnt == 2) ? 3'b010 : 3'b001,
                                data: shadow[idx], due: cyc + 1});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    vec_t idle_v;
    vec_t cr_v;
    vec_t all_v;
    vec_t tbl [10];

    task automatic seq_both(input int first, input string nm);
        vec_t v;
        int   other;
        other = (first == 2) ? 3 : 2;
        for (int k = 1; k <= 29; k++) begin
            v = all_v;
            if (k % 9 == 0)                 v.egnt = first;
            else if (k % 9 == 2 && k >= 11) v.egnt = other;
            v.ehold = (v.egnt != 1);
            step(v, nm);
        end
        step(idle_v, {nm, ".idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'h5A000000 + i * 32'h00010003;
            shadow[i] = 32'h5A000000 + i * 32'h00010003;
        end
        idle_v = mkv(0,0,4'h0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,4'h0,0);
        cr_v   = mkv(1,0,4'hF,32'h140,32'h0, 1,0,32'h180,32'h0, 0,0,32'h0,32'h0, 1,4'h0,0);
        all_v  = mkv(1,0,4'hF,32'h144,32'h0, 1,0,32'h184,32'h0, 1,0,32'h1C4,32'h0, 1,4'h0,0);

        tbl[0] = mkv(1,0,4'hF,32'h100,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,4'h0,0);
        tbl[1] = mkv(1,1,4'h3,32'h104,32'h11223344, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,4'h3,0);
        tbl[2] = mkv(1,0,4'hF,32'h108,32'h0, 1,0,32'h10C,32'h0, 1,0,32'h110,32'h0, 1,4'h0,0);
        tbl[3] = mkv(0,0,4'h0,32'h0,32'h0, 1,0,32'h114,32'h0, 1,0,32'h118,32'h0, 2,4'h0,0);
        tbl[4] = mkv(0,0,4'h0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,1,32'h11C,32'h0BADF00D, 3,4'hF,0);
        tbl[5] = mkv(0,0,4'h0,32'h0,32'h0, 1,1,32'h204,32'hCAFEF00D, 0,0,32'h0,32'h0, 2,4'hF,0);
        tbl[6] = mkv(1,1,4'hF,32'h120,32'h76543210, 1,1,32'h124,32'h99999999, 0,0,32'h0,32'h0, 1,4'hF,0);
        tbl[7] = mkv(0,0,4'h0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,0,32'h11C,32'h0, 3,4'h0,0);
        tbl[8] = mkv(1,0,4'h5,32'h104,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,4'h0,0);
        tbl[9] = mkv(0,0,4'h0,32'h0,32'h0, 1,0,32'h204,32'h0, 0,0,32'h0,32'h0, 2,4'h0,0);

        rst = 1'b1;
        core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_din = 0;
        ras_req = 0; ras_we = 0; ras_addr = 0; ras_din = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_din = 0;
        @(posedge clk);
        #1;

        // Reset holds everything quiet even with all ports requesting
        for (int k = 0; k < 3; k++) begin
            v = all_v; v.rst = 1'b1; v.egnt = 0; v.ehold = 1'b0;
            step(v, "reset");
        end

        for (int i = 0; i < 10; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
            step(idle_v, $sformatf("vec%0d.idle", i));
        end

        // RAS write and loader read of the same word in the same cycle
        step(mkv(0,0,4'h0,32'h0,32'h0, 1,1,32'h200,32'hDEADBEEF, 1,0,32'h200,32'h0, 2,4'hF,0), "rasw_ldrr.c1");
        step(mkv(0,0,4'h0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,0,32'h200,32'h0, 3,4'h0,0), "rasw_ldrr.c2");
        step(idle_v, "rasw_ldrr.c3");

        // Core hogging: RAS forced every 9th cycle
        for (int k = 1; k <= 27; k++) begin
            v = cr_v;
            if (k % 9 == 0) begin v.egnt = 2; v.ehold = 1'b1; end
            step(v, "starve_ras");
        end
        step(idle_v, "starve_ras.idle");

        // Previous force went to RAS, so a tie now goes to the loader first
        seq_both(3, "tie_ldr_first");

        // Forced port withdraws its request in the FORCE cycle
        for (int k = 1; k <= 12; k++) begin
            v = cr_v;
            if (k == 9) begin v.rreq = 1'b0; v.egnt = 0; v.ehold = 1'b1; end
            step(v, "force_drop");
        end
        step(idle_v, "force_drop.idle");

        // Reset lands on a FORCE cycle with a core read in flight
        for (int k = 1; k <= 10; k++) begin
            v = cr_v;
            if (k >= 9) begin v.rst = 1'b1; v.egnt = 0; v.ehold = 1'b0; end
            step(v, "rst_force");
        end
        for (int k = 1; k <= 9; k++) begin
            v = cr_v;
            if (k == 9) begin v.egnt = 2; v.ehold = 1'b1; end
            step(v, "post_rst");
        end
        step(idle_v, "post_rst.idle");

        // Reset restores loader as last forced, so RAS wins the first tie
        v = idle_v; v.rst = 1'b1;
        step(v, "rst2");
        seq_both(2, "tie_ras_first");

        step(idle_v, "drain");
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending reads want 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
